aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Control FSM for the byte-serial AES-128 encryption datapath: the SubBytes, byte-serial ShiftRows, MixColumns and AddRoundKey stages, 8 bits per cycle.
- Sequences 11 passes of 16 bytes each: round 0 (AddRoundKey only), rounds 1..9 (full), round 10 (no MixColumns).
- Generates byte/round indices for the key schedule and feedback buffer.
- Counts bytes returned by the datapath, using its ready/valid, to decide round completion.

Parameters:
- NB, 16, bytes per state block (byte counters are 4 bits wide).
- NR, 10, number of full+final rounds (round_idx is 4 bits wide).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin one block; sampled only in IDLE.
- in_valid  in  1  plaintext byte present on the external stream.
- in_ready  out  1  sequencer accepts a plaintext byte this cycle.
- dp_valid  in  1  datapath output byte valid (ShiftRows-chain ready).
- dp_issue  out  1  a byte enters the datapath this cycle.
- dp_src_sel  out  1  0 = plaintext stream, 1 = feedback buffer.
- byte_idx  out  4  index of the issued byte (key byte / feedback read address).
- ret_idx  out  4  index of the returned byte (feedback write address).
- fb_we  out  1  write returned byte into the feedback buffer.
- round_idx  out  4  current pass, 0..NR, to the key schedule.
- sub_bypass  out  1  bypass SubBytes.
- shift_bypass  out  1  bypass ShiftRows.
- mix_bypass  out  1  bypass MixColumns.
- out_valid  out  1  returned byte is a ciphertext byte.
- done  out  1  one-cycle pulse; block complete.
- busy  out  1  high in any state except IDLE.
- seq_err  out  1  sticky; dp_valid received with no byte outstanding.

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-block:
  - state=IDLE; iss_cnt, ret_cnt and round_idx = 0.
  - All outputs 0, including seq_err.
- States: IDLE, LOAD, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=0, dp_issue=0.
  - start=1 → LOAD; clears seq_err, round_idx=0.
- LOAD (round 0):
  - dp_src_sel=0; sub_bypass, shift_bypass and mix_bypass all =1.
  - in_ready = (iss_cnt issued < NB).
  - dp_issue = in_valid & in_ready; each issue increments iss_cnt.
- ROUND (round_idx 1..NR-1):
  - dp_src_sel=1, all bypasses =0.
  - dp_issue=1 every cycle until NB bytes are issued.
- FINAL (round_idx=NR): same as ROUND but mix_bypass=1.
- Counters:
  - byte_idx=iss_cnt and ret_idx=ret_cnt, both combinational.
  - iss_cnt increments on dp_issue; ret_cnt increments on dp_valid.
  - Both wrap 15→0, and both are cleared on a round transition.
- Returns:
  - fb_we=dp_valid in LOAD and ROUND.
  - out_valid=dp_valid in FINAL; fb_we=0 in FINAL.
- Round transition:
  - Taken on the edge at which dp_valid is high with ret_cnt=NB-1 (16th return).
  - LOAD→ROUND or ROUND→ROUND with round_idx+1.
  - When round_idx+1 = NR, the next state is FINAL.
  - FINAL→DONE.
  - The next pass issues from the following cycle. There is no overlap between passes: the feedback buffer must be complete before it is read.
- Round timing: with datapath latency L and no input stalls, one pass = NB+L cycles.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- start while busy: ignored, no effect.
- in_valid outside LOAD: ignored; in_ready stays 0.
- dp_valid when returns == issues in the current pass:
  - seq_err←1.
  - Counters and state unchanged.
  - Byte dropped: fb_we=0, out_valid=0.
- dp_valid in IDLE or DONE also sets seq_err.
- Input stall in LOAD: issuing pauses while in_valid=0; returns continue to be counted.

Decomposition:
- Package aes_seq_pkg holds:
  - state enum {IDLE, LOAD, ROUND, FINAL, DONE};
  - NB=16, NR=10 defaults;
  - the bypass-vector constants per state.
- One sub-module, aes_idx_counter: 4-bit counter with enable, synchronous clear and wrap flag (at NB-1).
  - Instantiated twice, for iss_cnt and ret_cnt.
- FSM and output decode live in the top module.

Test Plan:
- Nominal block:
  - Setup: datapath model with L=3, continuous in_valid; pulse start.
  - Pass timing: 11 passes of 19 cycles; round_idx steps 0..10.
  - Bypasses: mix_bypass=1 only in passes 0 and 10.
  - Returns: 16 out_valid pulses with ret_idx 0..15.
  - Completion: done exactly 1 cycle after the 16th FINAL return, then busy=0.
- Input stall:
  - Stimulus: in_valid low for cycles 5-9 of LOAD.
  - Response: byte_idx holds at 5 and no dp_issue during the stall; LOAD lasts 16+5+3 cycles; round 1 starts correctly.
- Start while busy: pulse start during round 4 → no state or counter change; exactly one done per block.
- Spurious dp_valid:
  - Stimulus: inject dp_valid in IDLE and once more after the 16th return of round 2.
  - Response: seq_err=1 sticky; round 3 still issues 16 bytes; seq_err cleared only by the next start.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 cycle during round 7, byte_idx=9.
  - Response: next cycle all outputs 0, state IDLE; a new start then completes a full 11-pass block.
- Back-to-back blocks: start asserted in the cycle after done → second block begins LOAD with round_idx=0 and iss_cnt=0.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the byte-serial AES-128 round sequencer.
package aes_seq_pkg;

    localparam int unsigned NB_DEF = 16;
    localparam int unsigned NR_DEF = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic sub;
        logic shift;
        logic mix;
    } bypass_t;

    localparam bypass_t BYP_NONE  = '{sub: 1'b0, shift: 1'b0, mix: 1'b0};
    localparam bypass_t BYP_LOAD  = '{sub: 1'b1, shift: 1'b1, mix: 1'b1};
    localparam bypass_t BYP_ROUND = '{sub: 1'b0, shift: 1'b0, mix: 1'b0};
    localparam bypass_t BYP_FINAL = '{sub: 1'b0, shift: 1'b0, mix: 1'b1};

    // Round 0 is AddRoundKey only; the last round skips MixColumns.
    function automatic bypass_t bypass_for(input seq_state_t s);
        case (s)
            LOAD:    return BYP_LOAD;
            ROUND:   return BYP_ROUND;
            FINAL:   return BYP_FINAL;
            default: return BYP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/aes_idx_counter.sv
// Byte index counter: enable, synchronous clear, wraps NB-1 -> 0 and flags the last index.
module aes_idx_counter
    import aes_seq_pkg::*;
#(
    parameter int unsigned NB = NB_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    output logic [$clog2(NB)-1:0] cnt,
    output logic                  wrap
);

    localparam int unsigned W = $clog2(NB);

    assign wrap = (cnt == W'(NB - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM for the byte-serial AES-128 datapath: sequences 11 passes of NB bytes,
// issues bytes, counts returns and drives the per-round bypass controls.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned NB = NB_DEF,
    parameter int unsigned NR = NR_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       dp_valid,
    output logic       dp_issue,
    output logic       dp_src_sel,
    output logic [3:0] byte_idx,
    output logic [3:0] ret_idx,
    output logic       fb_we,
    output logic [3:0] round_idx,
    output logic       sub_bypass,
    output logic       shift_bypass,
    output logic       mix_bypass,
    output logic       out_valid,
    output logic       done,
    output logic       busy,
    output logic       seq_err
);

    seq_state_t state;
    logic [3:0] round_q;
    logic [3:0] iss_cnt;
    logic [3:0] ret_cnt;
    logic       iss_wrap;
    logic       ret_wrap;
    logic       iss_full;
    logic       active;
    logic       issue_ok;
    logic       ret_ok;
    logic       pass_end;
    logic       cnt_clr;
    bypass_t    byp;

    assign active = (state == LOAD) || (state == ROUND) || (state == FINAL);

    // iss_full distinguishes "16 issued" from "0 issued" once the 4-bit counter has wrapped.
    assign issue_ok = active && !iss_full && ((state != LOAD) || in_valid);
    assign ret_ok   = active && dp_valid && (iss_full || (ret_cnt != iss_cnt));
    assign pass_end = ret_ok && ret_wrap;
    assign cnt_clr  = pass_end || ((state == IDLE) && start);

    aes_idx_counter #(.NB(NB)) u_iss_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (issue_ok),
        .clr  (cnt_clr),
        .cnt  (iss_cnt),
        .wrap (iss_wrap)
    );

    aes_idx_counter #(.NB(NB)) u_ret_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (ret_ok),
        .clr  (cnt_clr),
        .cnt  (ret_cnt),
        .wrap (ret_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            round_q  <= '0;
            iss_full <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        round_q  <= '0;
                        iss_full <= 1'b0;
                        seq_err  <= 1'b0;
                    end else if (dp_valid) begin
                        seq_err <= 1'b1;
                    end
                end
                LOAD, ROUND, FINAL: begin
                    if (dp_valid && !ret_ok) begin
                        seq_err <= 1'b1;
                    end
                    if (issue_ok && iss_wrap) begin
                        iss_full <= 1'b1;
                    end
                    // A pass ends only on its 16th return, so the next pass never overlaps it.
                    if (pass_end) begin
                        iss_full <= 1'b0;
                        if (state == FINAL) begin
                            state <= DONE;
                        end else begin
                            round_q <= round_q + 4'd1;
                            state   <= (round_q == 4'(NR - 1)) ? FINAL : ROUND;
                        end
                    end
                end
                DONE: begin
                    if (dp_valid) begin
                        seq_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        dp_issue   = 1'b0;
        dp_src_sel = 1'b0;
        fb_we      = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        byp        = bypass_for(state);
        case (state)
            LOAD: begin
                in_ready = !iss_full;
                dp_issue = issue_ok;
                fb_we    = ret_ok;
                busy     = 1'b1;
            end
            ROUND: begin
                dp_src_sel = 1'b1;
                dp_issue   = issue_ok;
                fb_we      = ret_ok;
                busy       = 1'b1;
            end
            FINAL: begin
                dp_src_sel = 1'b1;
                dp_issue   = issue_ok;
                out_valid  = ret_ok;
                busy       = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign sub_bypass   = byp.sub;
    assign shift_bypass = byp.shift;
    assign mix_bypass   = byp.mix;
    assign byte_idx     = iss_cnt;
    assign ret_idx      = ret_cnt;
    assign round_idx    = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a delay-line datapath model plus a pass/byte-count
// reference model checked every cycle, with directed and randomized block scenarios.
module tb_aes_round_sequencer;

    localparam int M_NOM   = 0;
    localparam int M_STALL = 1;
    localparam int M_BUSY  = 2;
    localparam int M_SPUR  = 3;
    localparam int M_RST   = 4;
    localparam int M_RAND  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       inject = 1'b0;
    logic       in_ready;
    logic       dp_valid;
    logic       dp_issue;
    logic       dp_src_sel;
    logic [3:0] byte_idx;
    logic [3:0] ret_idx;
    logic       fb_we;
    logic [3:0] round_idx;
    logic       sub_bypass;
    logic       shift_bypass;
    logic       mix_bypass;
    logic       out_valid;
    logic       done;
    logic       busy;
    logic       seq_err;

    logic [7:0] pipe = '0;
    int         lat = 3;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    // reference model: phase 0 idle, 1 running a pass, 2 done cycle
    int m_phase = 0;
    int m_pass  = 0;
    int m_iss   = 0;
    int m_ret   = 0;
    int m_err   = 0;

    int blk_ov   = 0;
    int blk_done = 0;
    int done_cyc = 0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NB(16), .NR(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dp_valid    (dp_valid),
        .dp_issue    (dp_issue),
        .dp_src_sel  (dp_src_sel),
        .byte_idx    (byte_idx),
        .ret_idx     (ret_idx),
        .fb_we       (fb_we),
        .round_idx   (round_idx),
        .sub_bypass  (sub_bypass),
        .shift_bypass(shift_bypass),
        .mix_bypass  (mix_bypass),
        .out_valid   (out_valid),
        .done        (done),
        .busy        (busy),
        .seq_err     (seq_err)
    );

    // datapath: every issued byte comes back exactly lat cycles later
    always @(posedge clk) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[6:0], dp_issue};
    end
    assign dp_valid = pipe[lat-1] | inject;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        bit act, dv, legit, e_issue;
        #1;
        dv      = dp_valid;
        act     = (m_phase == 1);
        e_issue = act && (m_iss < 16) && ((m_pass > 0) || in_valid);
        legit   = act && dv && (m_ret < m_iss);
        if (chk_en) begin
            chk("busy",         32'(busy),         32'(m_phase != 0));
            chk("done",         32'(done),         32'(m_phase == 2));
            chk("in_ready",     32'(in_ready),     32'(act && m_pass == 0 && m_iss < 16));
            chk("dp_issue",     32'(dp_issue),     32'(e_issue));
            chk("dp_src_sel",   32'(dp_src_sel),   32'(act && m_pass > 0));
            chk("byte_idx",     32'(byte_idx),     act ? m_iss % 16 : 0);
            chk("ret_idx",      32'(ret_idx),      act ? m_ret : 0);
            chk("round_idx",    32'(round_idx),    m_pass);
            chk("sub_bypass",   32'(sub_bypass),   32'(act && m_pass == 0));
            chk("shift_bypass", 32'(shift_bypass), 32'(act && m_pass == 0));
            chk("mix_bypass",   32'(mix_bypass),   32'(act && (m_pass == 0 || m_pass == 10)));
            chk("fb_we",        32'(fb_we),        32'(legit && m_pass < 10));
            chk("out_valid",    32'(out_valid),    32'(legit && m_pass == 10));
            chk("seq_err",      32'(seq_err),      m_err);
        end
        if (out_valid) blk_ov++;
        if (done) begin
            blk_done++;
            done_cyc = cyc;
        end
        if (!rst_n) begin
            m_phase = 0; m_pass = 0; m_iss = 0; m_ret = 0; m_err = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (start) begin
                        m_phase = 1; m_pass = 0; m_iss = 0; m_ret = 0; m_err = 0;
                    end else if (dv) begin
                        m_err = 1;
                    end
                end
                1: begin
                    if (e_issue) m_iss++;
                    if (dv && !legit) m_err = 1;
                    if (legit) begin
                        m_ret++;
                        if (m_ret == 16) begin
                            m_iss = 0;
                            m_ret = 0;
                            if (m_pass == 10) m_phase = 2;
                            else m_pass++;
                        end
                    end
                end
                default: begin
                    if (dv) m_err = 1;
                    m_phase = 0;
                end
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    // Runs one block from start; returns DUT done cycle relative to the first LOAD cycle.
    task automatic drive_block(input int mode, input int l, output int done_at);
        int  c0, guard, load_c;
        bit  fin, spur_hit;
        lat      = l;
        blk_ov   = 0;
        blk_done = 0;
        done_cyc = -1;
        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        start    = 1'b0;
        c0       = cyc;
        guard    = 0;
        load_c   = 0;
        fin      = 0;
        spur_hit = 0;
        while (!fin) begin
            if (guard >= 3000) begin
                chk("block_timeout", 0, 1);
                fin = 1;
            end else begin
                in_valid = (mode == M_RAND) ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (mode == M_STALL && m_phase == 1 && m_pass == 0) begin
                    in_valid = !(load_c >= 5 && load_c <= 9);
                    load_c++;
                end
                start  = (mode == M_BUSY && m_phase == 1 && m_pass == 4 && m_iss == 7);
                inject = 1'b0;
                if (mode == M_SPUR && !spur_hit && m_phase == 1 && m_pass == 3 && m_iss == 0 && m_ret == 0) begin
                    inject   = 1'b1;
                    spur_hit = 1;
                end
                rst_n = !(mode == M_RST && m_phase == 1 && m_pass == 7 && m_iss == 9);
                if (m_phase == 2 || !rst_n) fin = 1;
                tick();
                guard++;
            end
        end
        start    = 1'b0;
        inject   = 1'b0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        done_at  = (done_cyc < 0) ? -1 : done_cyc - c0;
    endtask

    initial begin
        int d;
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1;
        tick();
        tick();

        drive_block(M_NOM, 3, d);
        chk("nom_done_cycle", d, 209);
        chk("nom_out_valid_count", blk_ov, 16);
        chk("nom_done_count", blk_done, 1);

        drive_block(M_NOM, 3, d);
        chk("b2b_done_cycle", d, 209);

        tick();
        drive_block(M_STALL, 3, d);
        chk("stall_done_cycle", d, 214);
        chk("stall_out_valid_count", blk_ov, 16);

        tick();
        drive_block(M_BUSY, 3, d);
        chk("busy_start_done_cycle", d, 209);
        chk("busy_start_done_count", blk_done, 1);

        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        tick();
        tick();
        drive_block(M_SPUR, 3, d);
        chk("spur_done_cycle", d, 209);
        chk("spur_out_valid_count", blk_ov, 16);
        tick();
        tick();
        drive_block(M_NOM, 3, d);
        chk("after_spur_done_cycle", d, 209);

        tick();
        drive_block(M_RST, 3, d);
        chk("rst_no_done", blk_done, 0);
        tick();
        tick();
        drive_block(M_NOM, 3, d);
        chk("after_rst_done_cycle", d, 209);
        chk("after_rst_out_valid_count", blk_ov, 16);

        for (int b = 0; b < 5; b++) begin
            tick();
            drive_block(M_RAND, int'($urandom_range(1, 6)), d);
            chk("rand_out_valid_count", blk_ov, 16);
            chk("rand_done_count", blk_done, 1);
        end
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
